// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the data-memory and instruction-memory sides.
//   mem_state_t   : 2-bit access FSM encoding (IDLE, WAIT, ACCESS, RESP)
//   WE_RE_WRITE/READ : decoding of the core's we_re strobe
//   BYTE_W, NUM_LANES : byte-lane geometry of a 32-bit word
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } mem_state_t;

  localparam logic WE_RE_WRITE = 1'b1;
  localparam logic WE_RE_READ  = 1'b0;

  localparam int BYTE_W    = 8;
  localparam int NUM_LANES = 4;

endpackage

// File: rtl/sram_bytewise.sv
// sram_bytewise: single-port word SRAM with per-byte write enables and a
// registered (synchronous) read port.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset of the read register only
//   be     : byte write enables, bit i writes lane i of wdata
//   rd_en  : capture mem[addr] into rdata at the edge
//   rd_clr : force rdata to zero at the edge (takes priority over rd_en)
//   addr   : word index
//   wdata  : write data, lane aligned
//   rdata  : read register, holds its value when neither rd_en nor rd_clr
// Array contents are intentionally not reset.
module sram_bytewise
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            be,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Byte-lane writes; lanes with be=0 keep their old contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (be[i]) begin
        mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read register: doubles as the controller's load_data output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (rd_clr) begin
      rdata <= 32'd0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: fixed-wait-state data-memory controller for the RV32I core.
// Accepts one request in IDLE, waits WAIT_STATES cycles, performs the array
// access, then pulses valid for one cycle.
//   clk, rst   : clock, synchronous active-high reset
//   request    : access request (sampled only in IDLE)
//   we_re      : 1 = store, 0 = load
//   mask       : byte enables for stores
//   address    : byte address; word index = address[ADDR_WIDTH+1:2]
//   store_data : lane-aligned store data
//   valid      : one-cycle response strobe
//   load_data  : read word, held until the next completed read
//   busy       : high from acceptance through the RESP cycle
//   addr_err   : qualifies valid; address beyond the array
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        valid,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        addr_err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_t state;
  mem_state_t next_state;
  logic [3:0] cnt;

  logic                  lat_we;
  logic [3:0]            lat_mask;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_data;
  logic                  lat_err;

  // Dropping the byte offset first lets the range check consume every
  // remaining bit above the word index.
  logic [31:0] word_addr;
  logic        range_err;
  assign word_addr = address >> 2;
  assign range_err = (word_addr >> ADDR_WIDTH) != 32'd0;

  logic       access;
  logic [3:0] sram_be;
  logic       sram_rd_en;
  logic       sram_rd_clr;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (request) begin
          next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          next_state = ST_ACCESS;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_ACCESS: next_state = ST_RESP;
      ST_RESP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Array strobes; gated by rst so a reset on the ACCESS edge drops the write.
  always_comb begin
    access      = 1'b0;
    sram_be     = 4'b0000;
    sram_rd_en  = 1'b0;
    sram_rd_clr = 1'b0;
    if ((state == ST_ACCESS) && !rst) begin
      access = 1'b1;
    end else begin
      access = 1'b0;
    end
    if (access && lat_err) begin
      sram_rd_clr = 1'b1;
    end else if (access && (lat_we == WE_RE_WRITE)) begin
      sram_be = lat_mask;
    end else if (access && (lat_we == WE_RE_READ)) begin
      sram_rd_en = 1'b1;
    end else begin
      sram_be = 4'b0000;
    end
  end

  // Request latches, wait counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 4'd0;
      lat_we   <= 1'b0;
      lat_mask <= 4'd0;
      lat_addr <= '0;
      lat_data <= 32'd0;
      lat_err  <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && request) begin
        lat_we   <= we_re;
        lat_mask <= mask;
        lat_addr <= word_addr[ADDR_WIDTH-1:0];
        lat_data <= store_data;
        lat_err  <= range_err;
        cnt      <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end else begin
        cnt <= cnt;
      end
      valid    <= (state == ST_ACCESS);
      addr_err <= (state == ST_ACCESS) && lat_err;
      busy     <= (next_state != ST_IDLE);
    end
  end

  sram_bytewise #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk    (clk),
    .rst    (rst),
    .be     (sram_be),
    .rd_en  (sram_rd_en),
    .rd_clr (sram_rd_clr),
    .addr   (lat_addr),
    .wdata  (lat_data),
    .rdata  (load_data)
  );

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory controller sitting directly downstream of the RV32I core's memory stage. It accepts the core's single-outstanding data request (request, we_re, byte mask, address, store data), runs a fixed-wait-state access against an internal byte-enabled word SRAM, and returns a one-cycle `valid` pulse with the read word. It is the consumer of `data_mem_request`, `data_mem_we_re`, `mask_singal`, `alu_out_address` and `store_data_out`, and the producer of the core's `load_data_in` and data-valid input.

## Interface
- `ADDR_WIDTH`, 10: word-index bits; depth = 2^ADDR_WIDTH words.
- `WAIT_STATES`, 1: extra cycles inserted before the array access (0..15).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `request` in 1: access request from core; sampled only in IDLE.
- `we_re` in 1: 1 = write (store), 0 = read (load).
- `mask` in 4: byte enables, bit i = byte lane i (bits [8i+7:8i]).
- `address` in 32: byte address; bits [1:0] ignored, word index = address[ADDR_WIDTH+1:2].
- `store_data` in 32: write data, already lane-aligned by the core.
- `valid` out 1: one-cycle response strobe.
- `load_data` out 32: read word, meaningful while `valid`=1 on a read.
- `busy` out 1: high from the cycle after acceptance through the RESP cycle.
- `addr_err` out 1: qualifies `valid`; address outside array range.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: if `request`=1, latch `we_re`, `mask`, `address`, `store_data`; range check = address[31:ADDR_WIDTH+2] nonzero -> latched error flag. Next = WAIT if WAIT_STATES>0 else ACCESS. Counter loaded with WAIT_STATES-1.
- WAIT: counter decrements each cycle; leave to ACCESS when counter = 0. Inputs ignored.
- ACCESS: at the closing edge, write: bytes with mask=1 updated, others unchanged; read: full word registered into `load_data` (mask ignored). Error flag set: no array write, `load_data` <= 0.
- RESP: `valid`=1, `addr_err`=latched flag. Next = IDLE unconditionally; `request` not sampled in RESP.
- Write with mask=4'b0000: no byte changes, response still issued.
- `load_data` holds its value after RESP until the next read completes; writes do not alter it.
- Reset, any state: FSM -> IDLE, counter 0, `valid`/`busy`/`addr_err`/`load_data` = 0; a latched write not yet at ACCESS edge is dropped. Array contents are not reset.
- Request held high continuously: re-accepted in the IDLE cycle after RESP.

## Timing
- Acceptance edge E0 (IDLE, `request`=1). `valid` high in the cycle following edge E0+WAIT_STATES+1; i.e. latency WAIT_STATES+1 cycles, pulse width 1.
- Write commits at edge E0+WAIT_STATES+1 (end of ACCESS); a read accepted in the next IDLE observes it.
- Throughput: one access per WAIT_STATES+3 cycles (IDLE, WAIT×N, ACCESS, RESP).
- `busy` high from edge E0 until edge closing RESP; low in IDLE.
- All outputs registered; no combinational input-to-output path.

## Structure
- Shared package `mem_pkg`: FSM state encoding (2-bit), `WE_RE_WRITE`=1'b1 / `WE_RE_READ`=1'b0, byte-lane width constant; reused by instruction-memory side.
- One sub-module: `sram_bytewise` — single-port, synchronous read, per-byte write enable, parameter ADDR_WIDTH; controller owns FSM, counter, latches, range check.

## Test plan
- Reset then idle, `request`=0 for 10 cycles -> `valid`,`busy`,`addr_err`,`load_data` all 0 throughout.
- WAIT_STATES=1: write 0xDEADBEEF to 0x0000_0010 mask 4'hF, then read 0x10 -> each `valid` exactly 2 cycles after accept edge; read returns 0xDEADBEEF.
- Byte write 0x0000_00AA at 0x10 mask 4'b0001 over 0xDEADBEEF, read back -> 0xDEADBEAA; mask 4'b0000 write -> word unchanged, `valid` still pulses.
- WAIT_STATES=0, `request` held high with alternating reads -> accepts every 3 cycles, `valid` one cycle after each accept.
- Read 0x0000_1000 with ADDR_WIDTH=10 -> `valid`=1, `addr_err`=1, `load_data`=0; write there leaves word 0 unchanged.
- Assert `rst` during WAIT of a write to 0x20 -> next cycle IDLE, outputs 0; subsequent read of 0x20 returns prior contents.
